// File: rtl/rv_dmem_mmio.sv
// Data-side memory subsystem: byte-strobed word RAM plus an MMIO block holding a
// 64-bit machine timer with compare interrupt and a console TX byte FIFO.
module rv_dmem_mmio #(
  parameter int               XLEN          = 32,
  parameter int               RAM_DEPTH     = 1024,
  parameter logic [XLEN-1:0]  MMIO_BASE     = 32'h1000_0000,
  parameter int               TX_FIFO_DEPTH = 8,
  parameter int               TIMER_DIV     = 1
) (
  input  logic              i_dm_clk,
  input  logic              i_dm_rstn,
  input  logic [XLEN-1:0]   i_dm_addr,
  input  logic              i_dm_wen,
  input  logic [XLEN/8-1:0] i_dm_wstrb,
  input  logic [XLEN-1:0]   i_dm_wdata,
  output logic [XLEN-1:0]   o_dm_rdata,
  output logic              o_dm_tx_valid,
  output logic [7:0]        o_dm_tx_data,
  input  logic              i_dm_tx_ready,
  output logic              o_dm_timer_irq
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  localparam logic [DW-1:0] PRESC_MAX = DW'(TIMER_DIV - 1);
  localparam logic [CW-1:0] FIFO_CAP  = CW'(TX_FIFO_DEPTH);

  localparam logic [XLEN-1:0] OFF_MTIME_LO    = 'h00;
  localparam logic [XLEN-1:0] OFF_MTIME_HI    = 'h04;
  localparam logic [XLEN-1:0] OFF_MTIMECMP_LO = 'h08;
  localparam logic [XLEN-1:0] OFF_MTIMECMP_HI = 'h0C;
  localparam logic [XLEN-1:0] OFF_STATUS      = 'h10;
  localparam logic [XLEN-1:0] OFF_TXDATA      = 'h14;

  function automatic logic [XLEN-1:0] merge_bytes(
    input logic [XLEN-1:0] old_word,
    input logic [XLEN-1:0] new_word,
    input logic [NB-1:0]   strb
  );
    logic [XLEN-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

  logic            is_mmio;
  logic [XLEN-1:0] mmio_off;
  logic [AW-1:0]   ram_idx;
  logic            wr_any;
  logic            sel_mtime_lo, sel_mtime_hi, sel_cmp_lo, sel_cmp_hi;
  logic            sel_status, sel_txdata;
  logic            wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;

  assign is_mmio      = (i_dm_addr >= MMIO_BASE);
  assign mmio_off     = i_dm_addr - MMIO_BASE;
  assign ram_idx      = i_dm_addr[AW+1:2];
  assign wr_any       = i_dm_wen & (|i_dm_wstrb);

  assign sel_mtime_lo = is_mmio & (mmio_off == OFF_MTIME_LO);
  assign sel_mtime_hi = is_mmio & (mmio_off == OFF_MTIME_HI);
  assign sel_cmp_lo   = is_mmio & (mmio_off == OFF_MTIMECMP_LO);
  assign sel_cmp_hi   = is_mmio & (mmio_off == OFF_MTIMECMP_HI);
  assign sel_status   = is_mmio & (mmio_off == OFF_STATUS);
  assign sel_txdata   = is_mmio & (mmio_off == OFF_TXDATA);

  assign wr_mtime_lo  = wr_any & sel_mtime_lo;
  assign wr_mtime_hi  = wr_any & sel_mtime_hi;
  assign wr_cmp_lo    = wr_any & sel_cmp_lo;
  assign wr_cmp_hi    = wr_any & sel_cmp_hi;

  // Data RAM: contents survive reset; reads see the pre-edge word.
  logic [XLEN-1:0] ram [RAM_DEPTH];

  always_ff @(posedge i_dm_clk) begin
    if (i_dm_wen && !is_mmio) begin
      for (int k = 0; k < NB; k++) begin
        if (i_dm_wstrb[k]) ram[ram_idx][8*k +: 8] <= i_dm_wdata[8*k +: 8];
      end
    end
  end

  logic [XLEN-1:0] mtime_lo, mtime_hi;
  logic [XLEN-1:0] mtimecmp_lo, mtimecmp_hi;
  logic [DW-1:0]   presc;
  logic            tick;
  logic            lo_carry;
  logic            mtime_ge;
  logic            timer_irq;

  assign tick     = (presc == PRESC_MAX);
  // A written LO half does not increment, so it cannot carry either.
  assign lo_carry = tick & ~wr_mtime_lo & (&mtime_lo);
  assign mtime_ge = ({mtime_hi, mtime_lo} >= {mtimecmp_hi, mtimecmp_lo});

  always_ff @(posedge i_dm_clk or negedge i_dm_rstn) begin
    if (!i_dm_rstn) begin
      presc    <= '0;
      mtime_lo <= '0;
      mtime_hi <= '0;
    end else begin
      if (wr_mtime_lo || wr_mtime_hi || tick) presc <= '0;
      else                                    presc <= presc + 1'b1;

      if (wr_mtime_lo)  mtime_lo <= merge_bytes(mtime_lo, i_dm_wdata, i_dm_wstrb);
      else if (tick)    mtime_lo <= mtime_lo + 1'b1;

      if (wr_mtime_hi)  mtime_hi <= merge_bytes(mtime_hi, i_dm_wdata, i_dm_wstrb);
      else if (lo_carry) mtime_hi <= mtime_hi + 1'b1;
    end
  end

  always_ff @(posedge i_dm_clk or negedge i_dm_rstn) begin
    if (!i_dm_rstn) begin
      mtimecmp_lo <= '1;
      mtimecmp_hi <= '1;
      timer_irq   <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp_lo <= merge_bytes(mtimecmp_lo, i_dm_wdata, i_dm_wstrb);
      if (wr_cmp_hi) mtimecmp_hi <= merge_bytes(mtimecmp_hi, i_dm_wdata, i_dm_wstrb);
      timer_irq <= mtime_ge;
    end
  end

  assign o_dm_timer_irq = timer_irq;

  // Console TX FIFO: a push into a full FIFO still lands when the head leaves this cycle.
  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          push_req, push, pop;
  logic          ovf_set, ovf_clr, tx_overflow;

  assign fifo_full  = (count == FIFO_CAP);
  assign fifo_empty = (count == '0);
  assign push_req   = i_dm_wen & sel_txdata & i_dm_wstrb[0];
  assign pop        = ~fifo_empty & i_dm_tx_ready;
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;
  assign ovf_clr    = i_dm_wen & sel_status & i_dm_wstrb[0] & i_dm_wdata[3];

  always_ff @(posedge i_dm_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_dm_wdata[7:0];
  end

  always_ff @(posedge i_dm_clk or negedge i_dm_rstn) begin
    if (!i_dm_rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      tx_overflow <= 1'b1;
      else if (ovf_clr) tx_overflow <= 1'b0;
    end
  end

  assign o_dm_tx_valid = ~fifo_empty;
  assign o_dm_tx_data  = fifo_mem[rd_ptr];

  always_comb begin
    o_dm_rdata = '0;
    if (!is_mmio) begin
      o_dm_rdata = ram[ram_idx];
    end else begin
      case (mmio_off)
        OFF_MTIME_LO:    o_dm_rdata = mtime_lo;
        OFF_MTIME_HI:    o_dm_rdata = mtime_hi;
        OFF_MTIMECMP_LO: o_dm_rdata = mtimecmp_lo;
        OFF_MTIMECMP_HI: o_dm_rdata = mtimecmp_hi;
        OFF_STATUS:      o_dm_rdata = XLEN'({tx_overflow, timer_irq, fifo_empty, fifo_full});
        default:         o_dm_rdata = '0;
      endcase
    end
  end

endmodule
